// File: rtl/bootrom_arb_pkg.sv
//==============================================================================
// Module      : bootrom_arb_pkg
// Description : Shared constants and types for the boot-memory arbiter.
//               Optional macro used by this block: BOOTARB_RR_EN
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bootrom_arb_pkg;

    // Default geometry of the 16x16 boot memory and its write-protected image
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_RO_WORDS = 8;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FAULT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Transaction owner: 0 = CPU port (r0), 1 = debug/loader port (r1)
    typedef logic owner_t;

    localparam owner_t OWNER_R0 = 1'b0;
    localparam owner_t OWNER_R1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bootrom_arb_pick.sv
//==============================================================================
// Module      : bootrom_arb_pick
// Description : Combinational two-way winner select for the boot-memory
//               arbiter. BOOTARB_RR_EN selects round-robin tie breaking;
//               otherwise r0 has fixed priority.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bootrom_arb_pick
    import bootrom_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last,
    output owner_t win
);

`ifdef BOOTARB_RR_EN
    // On a tie the requester that was not granted last time wins
    always_comb begin
        if (req0 && req1) begin
            win = owner_t'(~last);
        end else if (req1) begin
            win = OWNER_R1;
        end else begin
            win = OWNER_R0;
        end
    end
`else
    // The grant history is kept by the sequencer but plays no part here
    logic unused_last;
    assign unused_last = last;

    // Fixed priority: r1 only wins when r0 is not requesting
    always_comb begin
        win = (req1 && !req0) ? OWNER_R1 : OWNER_R0;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/bootrom_arbiter.sv
//==============================================================================
// Module      : bootrom_arbiter
// Description : Two-requester arbiter and access sequencer in front of the
//               16x16 boot memory. Words below RO_WORDS are write-protected;
//               a write there completes with an error and never reaches the
//               memory. Optional macro: BOOTARB_RR_EN (round-robin ties).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bootrom_arbiter
    import bootrom_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RO_WORDS = DEF_RO_WORDS
) (
    input  logic              romclk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,

    output logic              busy
);

    state_t              state_q,    state_d;
    owner_t              owner_q,    owner_d;
    owner_t              last_q,     last_d;
    logic                we_q,       we_d;
    logic                err_q,      err_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [DATA_W-1:0]   r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0]   r1_rdata_q, r1_rdata_d;

    owner_t              win;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_prot;

    bootrom_arb_pick u_pick (
        .req0 (r0_req),
        .req1 (r1_req),
        .last (last_q),
        .win  (win)
    );

    // Mux the winning requester's command and flag writes into the image
    always_comb begin
        sel_we    = (win == OWNER_R1) ? r1_we    : r0_we;
        sel_addr  = (win == OWNER_R1) ? r1_addr  : r0_addr;
        sel_wdata = (win == OWNER_R1) ? r1_wdata : r0_wdata;
        sel_prot  = sel_we && (int'(sel_addr) < RO_WORDS);
    end

    // Sequencer next state: latch in IDLE, one memory or fault cycle, then ack
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        r0_rdata_d = r0_rdata_q;
        r1_rdata_d = r1_rdata_q;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    owner_d = win;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = sel_prot;
                    state_d = sel_prot ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (owner_q == OWNER_R1) begin
                        r1_rdata_d = mem_dout;
                    end else begin
                        r0_rdata_d = mem_dout;
                    end
                end
                state_d = DONE;
            end
            FAULT: begin
                state_d = DONE;
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge romclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_R0;
            last_q     <= OWNER_R1;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
        end
    end

    // Memory bus is driven only in ACCESS and parked at zero otherwise
    always_comb begin
        mem_cs   = (state_q == ACCESS);
        mem_we   = mem_cs && we_q;
        mem_addr = mem_cs ? addr_q  : '0;
        mem_din  = mem_cs ? wdata_q : '0;
        busy     = (state_q != IDLE);
        r0_ack   = (state_q == DONE) && (owner_q == OWNER_R0);
        r1_ack   = (state_q == DONE) && (owner_q == OWNER_R1);
        r0_err   = r0_ack && err_q;
        r1_err   = r1_ack && err_q;
        r0_rdata = r0_rdata_q;
        r1_rdata = r1_rdata_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_bootrom_arbiter.sv
//==============================================================================
// Module      : tb_bootrom_arbiter
// Description : Self-checking bench for bootrom_arbiter with a behavioural
//               boot-memory model and a transaction-level reference model.
//               Honours BOOTARB_RR_EN for the expected arbitration order.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bootrom_arbiter;

    localparam int RO = 8;

    logic        romclk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r0_ack, r0_err;
    logic [3:0]  r0_addr;
    logic [15:0] r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_ack, r1_err;
    logic [3:0]  r1_addr;
    logic [15:0] r1_wdata, r1_rdata;
    logic        mem_cs, mem_we, busy;
    logic [3:0]  mem_addr;
    logic [15:0] mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    always #5 romclk = ~romclk;

    bootrom_arbiter dut (
        .romclk   (romclk),   .rst      (rst),
        .r0_req   (r0_req),   .r0_we    (r0_we),   .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata), .r0_ack   (r0_ack),  .r0_err   (r0_err),
        .r0_rdata (r0_rdata),
        .r1_req   (r1_req),   .r1_we    (r1_we),   .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata), .r1_ack   (r1_ack),  .r1_err   (r1_err),
        .r1_rdata (r1_rdata),
        .mem_cs   (mem_cs),   .mem_we   (mem_we),  .mem_addr (mem_addr),
        .mem_din  (mem_din),  .mem_dout (mem_dout),
        .busy     (busy)
    );

    // Boot memory: image in words 0-7, scratch in 8-F, asynchronous read
    logic [15:0] mem [16] = '{16'hC0DE, 16'h5A5A, 16'hF800, 16'h1007,
                              16'h2222, 16'h3333, 16'h4444, 16'h5555,
                              16'h8001, 16'h9002, 16'hA003, 16'hB004,
                              16'hC005, 16'hD006, 16'hE007, 16'hF008};
    assign mem_dout = mem[mem_addr];

    // Reference model state: what memory and the read registers should hold
    logic [15:0] ref_mem [16] = '{16'hC0DE, 16'h5A5A, 16'hF800, 16'h1007,
                                  16'h2222, 16'h3333, 16'h4444, 16'h5555,
                                  16'h8001, 16'h9002, 16'hA003, 16'hB004,
                                  16'hC005, 16'hD006, 16'hE007, 16'hF008};
    logic [15:0] exp_rd0, exp_rd1;
    bit          exp_last;

    // Bus monitor sampled mid-cycle; also performs the memory write
    int          cs_cnt = 0, ro_wr_cnt = 0, idle_viol = 0;
    int          ack0_cnt = 0, ack1_cnt = 0, dual_ack = 0;
    logic        last_cs_we;
    logic [3:0]  last_cs_addr;
    logic [15:0] last_cs_din;
    always @(negedge romclk) begin
        if (mem_cs) begin
            cs_cnt++;
            last_cs_we   = mem_we;
            last_cs_addr = mem_addr;
            last_cs_din  = mem_din;
            if (mem_we) mem[mem_addr] = mem_din;
        end
        if (mem_cs && mem_we && int'(mem_addr) < RO) ro_wr_cnt++;
        if (!mem_cs && (mem_we || mem_addr != 4'h0 || mem_din != 16'h0)) idle_viol++;
        if (r0_ack) ack0_cnt++;
        if (r1_ack) ack1_cnt++;
        if (r0_ack && r1_ack) dual_ack++;
    end

    // Transaction-level rule: protected writes fault, reads return memory
    task automatic model_txn(input bit who, input bit we, input logic [3:0] addr,
                             input logic [15:0] wd, output bit exp_err);
        exp_err = we && (int'(addr) < RO);
        if (!we) begin
            if (who) exp_rd1 = ref_mem[addr];
            else     exp_rd0 = ref_mem[addr];
        end else if (!exp_err) begin
            ref_mem[addr] = wd;
        end
        exp_last = who;
    endtask

    // Issue one transaction from IDLE, return latency in edges (99 = timeout)
    task automatic run_txn(input bit who, input bit we, input logic [3:0] addr,
                           input logic [15:0] wd, output int lat, output bit err,
                           output logic [15:0] rd0, output logic [15:0] rd1);
        if (who) begin
            r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end else begin
            r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end
        lat = 99;
        for (int c = 1; c <= 8; c++) begin
            @(posedge romclk); #1;
            if ((who ? r1_ack : r0_ack) === 1'b1) begin
                lat = c;
                break;
            end
        end
        err = who ? r1_err : r0_err;
        rd0 = r0_rdata;
        rd1 = r1_rdata;
        r0_req = 1'b0;
        r1_req = 1'b0;
        @(posedge romclk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        repeat (2) @(posedge romclk);
        #1;
        checks++;
        if ({busy, mem_cs, mem_we, r0_ack, r0_err, r1_ack, r1_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {busy, mem_cs, mem_we, r0_ack, r0_err, r1_ack, r1_err});
        end
        checks++;
        if ({mem_addr, mem_din, r0_rdata, r1_rdata} !== 52'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_din, r0_rdata, r1_rdata});
        end
        rst = 1'b0;
        exp_rd0 = 16'h0; exp_rd1 = 16'h0; exp_last = 1'b1;
        @(posedge romclk); #1;
    endtask

    task automatic test_rom_read();
        int lat; bit err, e_err; logic [15:0] rd0, rd1; int cs0;
        cs0 = cs_cnt;
        run_txn(1'b0, 1'b0, 4'h3, 16'h0, lat, err, rd0, rd1);
        model_txn(1'b0, 1'b0, 4'h3, 16'h0, e_err);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL rom_read_lat: got %0d expected 2", lat); end
        checks++;
        if (rd0 !== 16'h1007 || rd0 !== exp_rd0) begin
            errors++; $display("FAIL rom_read_data: got %h expected 1007", rd0);
        end
        checks++;
        if (err !== e_err) begin errors++; $display("FAIL rom_read_err: got %b expected %b", err, e_err); end
        checks++;
        if (cs_cnt - cs0 !== 1) begin
            errors++; $display("FAIL rom_read_cs: got %0d cs cycles expected 1", cs_cnt - cs0);
        end
    endtask

    task automatic test_scratch_wr_rd();
        int lat; bit err, e_err; logic [15:0] rd0, rd1;
        run_txn(1'b1, 1'b1, 4'h9, 16'hABCD, lat, err, rd0, rd1);
        model_txn(1'b1, 1'b1, 4'h9, 16'hABCD, e_err);
        checks++;
        if (lat !== 2 || err !== 1'b0) begin
            errors++; $display("FAIL scratch_wr_ack: got lat %0d err %b expected lat 2 err 0", lat, err);
        end
        checks++;
        if ({last_cs_we, last_cs_addr, last_cs_din} !== {1'b1, 4'h9, 16'hABCD}) begin
            errors++; $display("FAIL scratch_wr_bus: got we %b addr %h din %h expected 1 9 abcd",
                               last_cs_we, last_cs_addr, last_cs_din);
        end
        checks++;
        if (rd1 !== exp_rd1) begin errors++; $display("FAIL scratch_wr_rdata: got %h expected %h", rd1, exp_rd1); end
        run_txn(1'b1, 1'b0, 4'h9, 16'h0, lat, err, rd0, rd1);
        model_txn(1'b1, 1'b0, 4'h9, 16'h0, e_err);
        checks++;
        if (rd1 !== 16'hABCD || rd1 !== exp_rd1) begin
            errors++; $display("FAIL scratch_rd_data: got %h expected abcd", rd1);
        end
        checks++;
        if (rd0 !== exp_rd0) begin errors++; $display("FAIL scratch_r0_hold: got %h expected %h", rd0, exp_rd0); end
    endtask

    task automatic test_fault();
        int lat; bit err, e_err; logic [15:0] rd0, rd1; int cs0;
        cs0 = cs_cnt;
        run_txn(1'b0, 1'b1, 4'h2, 16'h1234, lat, err, rd0, rd1);
        model_txn(1'b0, 1'b1, 4'h2, 16'h1234, e_err);
        checks++;
        if (lat !== 2 || err !== 1'b1) begin
            errors++; $display("FAIL fault_ack: got lat %0d err %b expected lat 2 err 1", lat, err);
        end
        checks++;
        if (cs_cnt - cs0 !== 0) begin errors++; $display("FAIL fault_cs: got %0d cs cycles expected 0", cs_cnt - cs0); end
        run_txn(1'b0, 1'b0, 4'h2, 16'h0, lat, err, rd0, rd1);
        model_txn(1'b0, 1'b0, 4'h2, 16'h0, e_err);
        checks++;
        if (rd0 !== 16'hF800 || err !== 1'b0) begin
            errors++; $display("FAIL fault_readback: got %h err %b expected f800 err 0", rd0, err);
        end
    endtask

    task automatic test_back_to_back();
        int got; bit who, e_who, e_err;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'h5; r0_wdata = 16'h0;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'hC; r1_wdata = 16'h0;
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(posedge romclk); #1;
            if (r0_ack || r1_ack) begin
                who = r1_ack;
`ifdef BOOTARB_RR_EN
                e_who = ~exp_last;
`else
                e_who = 1'b0;
`endif
                model_txn(e_who, 1'b0, e_who ? 4'hC : 4'h5, 16'h0, e_err);
                checks++;
                if (who !== e_who || (r0_ack && r1_ack)) begin
                    errors++; $display("FAIL b2b_grant%0d: got r%0d expected r%0d", got, who, e_who);
                end
                checks++;
                if ((e_who ? r1_rdata : r0_rdata) !== (e_who ? exp_rd1 : exp_rd0)) begin
                    errors++; $display("FAIL b2b_rdata%0d: got %h expected %h", got,
                                       e_who ? r1_rdata : r0_rdata, e_who ? exp_rd1 : exp_rd0);
                end
                got++;
                if (got == 4) begin r0_req = 1'b0; r1_req = 1'b0; end
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        checks++;
        if (got !== 4) begin errors++; $display("FAIL b2b_count: got %0d grants expected 4", got); end
        @(posedge romclk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, a1; bit err, e_err; logic [15:0] rd0, rd1;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'h9;
        @(posedge romclk); #1;
        checks++;
        if (mem_cs !== 1'b1) begin errors++; $display("FAIL rstmid_access: got cs %b expected 1", mem_cs); end
        a1 = ack1_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, mem_cs, r1_ack, r1_rdata, r0_rdata} !== 35'h0) begin
            errors++; $display("FAIL rstmid_clear: got busy %b cs %b ack %b rd1 %h rd0 %h expected all 0",
                               busy, mem_cs, r1_ack, r1_rdata, r0_rdata);
        end
        r1_req = 1'b0;
        @(posedge romclk); #1;
        rst = 1'b0;
        exp_rd0 = 16'h0; exp_rd1 = 16'h0; exp_last = 1'b1;
        repeat (3) @(posedge romclk);
        #1;
        checks++;
        if (ack1_cnt !== a1) begin errors++; $display("FAIL rstmid_noack: got %0d acks expected 0", ack1_cnt - a1); end
        run_txn(1'b1, 1'b0, 4'h9, 16'h0, lat, err, rd0, rd1);
        model_txn(1'b1, 1'b0, 4'h9, 16'h0, e_err);
        checks++;
        if (lat !== 2 || rd1 !== exp_rd1 || rd0 !== exp_rd0) begin
            errors++; $display("FAIL rstmid_recover: got lat %0d rd1 %h rd0 %h expected 2 %h %h",
                               lat, rd1, rd0, exp_rd1, exp_rd0);
        end
    endtask

    task automatic test_drop_req();
        int lat, a0; bit e_err;
        a0 = ack0_cnt;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'h4;
        @(posedge romclk); #1;
        r0_req = 1'b0;
        lat = 99;
        for (int c = 2; c <= 8; c++) begin
            @(posedge romclk); #1;
            if (r0_ack === 1'b1) begin lat = c; break; end
        end
        model_txn(1'b0, 1'b0, 4'h4, 16'h0, e_err);
        checks++;
        if (lat !== 2 || r0_rdata !== exp_rd0) begin
            errors++; $display("FAIL drop_req: got lat %0d rd %h expected 2 %h", lat, r0_rdata, exp_rd0);
        end
        repeat (4) @(posedge romclk);
        #1;
        checks++;
        if (ack0_cnt - a0 !== 1) begin errors++; $display("FAIL drop_req_acks: got %0d expected 1", ack0_cnt - a0); end
    endtask

    task automatic test_random();
        int lat, cs0; bit who, we, err, e_err; logic [3:0] addr; logic [15:0] wd, rd0, rd1;
        for (int i = 0; i < 40; i++) begin
            who  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            wd   = 16'($urandom);
            cs0  = cs_cnt;
            run_txn(who, we, addr, wd, lat, err, rd0, rd1);
            model_txn(who, we, addr, wd, e_err);
            checks++;
            if (lat !== 2 || err !== e_err || rd0 !== exp_rd0 || rd1 !== exp_rd1 ||
                (cs_cnt - cs0) !== (e_err ? 0 : 1)) begin
                errors++;
                $display("FAIL rand%0d r%0d we %b addr %h: got lat %0d err %b rd0 %h rd1 %h cs %0d expected 2 %b %h %h %0d",
                         i, who, we, addr, lat, err, rd0, rd1, cs_cnt - cs0,
                         e_err, exp_rd0, exp_rd1, e_err ? 0 : 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_scratch_wr_rd();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        test_drop_req();
        test_random();
        checks++;
        if (ro_wr_cnt !== 0 || idle_viol !== 0 || dual_ack !== 0) begin
            errors++; $display("FAIL bus_rules: got ro_writes %0d idle_viol %0d dual_ack %0d expected 0 0 0",
                               ro_wr_cnt, idle_viol, dual_ack);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
